control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Moore FSM that sequences the datapath. Runs fetch T0-T2, then per-opcode execute steps, then returns to T0.
//  Drives every datapath control strobe; the only inputs it decodes are IR[31:27] and CON_FF.
//  Replaces bench-driven control for full-program runs.
// PARAMETERS
//  MEM_WAIT  0   extra cycles MDR_read is held before MDR_enable fires (memory latency, 0..15)
// PORTS
//  Clock    in   1   system clock; all state updates on the rising edge
//  Clear    in   1   reset, asynchronous, active-low
//  IR       in   32  instruction register; opcode = IR[31:27]
//  CON_FF   in   1   branch condition flag from the datapath
//  PCout,ZLowout,ZHighout,MDRout,HIout,LOout,InPortout,BAout,Cout  out 1 each  bus drivers
//  PC_enable,IncPC,MAR_enable,MDR_enable,MDR_read,IR_enable,Y_enable  out 1 each  register loads
//  ZLowIn,ZHighIn,HI_enable,LO_enable,CON_enable,OutPort_enable,RAM_write  out 1 each  loads/strobes
//  Gra,Grb,Grc,R_in,R_out  out 1 each  register-file field select and in/out
//  ALU_op   out  5   ALU operation code
//  Run      out  1   1 = executing; 0 = reset or halted
// BEHAVIOUR
//  States: RST, T0..T7, WAIT, HALT. Outputs are a function of (state, opcode) only; no input-to-output combinational path except CON_FF at br T6.
//  Clear low: state = RST immediately, even mid-instruction. All outputs are 0, including Run and ALU_op.
//  First rising edge with Clear high: RST -> T0. Run = 1 in every state except RST and HALT.
//  Any strobe not listed for a step is 0. ALU_op = 0 except where marked ALUop or ADD.
//  ALUop = IR[31:27]; ADD = 5'b00011.
//  Fetch (all opcodes):
//   T0: PCout, MAR_enable, IncPC, ZLowIn.
//   T1: ZLowout, PC_enable, MDR_read. Go to WAIT if MEM_WAIT > 0; otherwise assert MDR_enable.
//   WAIT: MDR_read held MEM_WAIT cycles; MDR_enable is asserted on the last one; then go to T2.
//   T2: MDRout, IR_enable.
//  Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000,
//   shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001,
//   not 10010, br 10011, jr 10100, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
//  Any other opcode executes as nop.
//  R-type (add..rol): T3 Grb,R_out,Y_enable | T4 Grc,R_out,ALUop,ZLowIn | T5 ZLowout,Gra,R_in.
//  Immediate (addi,andi,ori): T3 Grb,R_out,Y_enable | T4 Cout,ALUop,ZLowIn | T5 ZLowout,Gra,R_in.
//  mul/div: T3 Gra,R_out,Y_enable | T4 Grb,R_out,ALUop,ZHighIn,ZLowIn | T5 ZLowout,LO_enable | T6 ZHighout,HI_enable.
//  neg/not: T3 Grb,R_out,ALUop,ZLowIn | T4 ZLowout,Gra,R_in.
//  ld/ldi/st, shared address steps: T3 Grb,BAout,Y_enable | T4 Cout,ADD,ZLowIn.
//   ldi: T5 ZLowout,Gra,R_in.
//   ld:  T5 ZLowout,MAR_enable | T6 MDR_read (+ WAIT as in fetch), MDR_enable | T7 MDRout,Gra,R_in.
//   st:  T5 ZLowout,MAR_enable | T6 Gra,R_out,MDR_enable (MDR_read = 0) | T7 RAM_write, asserted for exactly 1 cycle.
//  br: T3 Gra,R_out,CON_enable | T4 PCout,Y_enable | T5 Cout,ADD,ZLowIn | T6 ZLowout, plus PC_enable only if CON_FF = 1.
//  jr: T3 Gra,R_out,PC_enable.
//  in: T3 InPortout,Gra,R_in.  out: T3 Gra,R_out,OutPort_enable.
//  mfhi: T3 HIout,Gra,R_in.  mflo: T3 LOout,Gra,R_in.
//  nop: T2 -> T0.  halt: T2 -> HALT.
//  HALT: all outputs 0, Run = 0. Held until Clear is driven low.
//  The last step of every instruction goes to T0 on the next edge.
//  No two bus drivers are ever high in the same state.
//  WAIT counter: 4 bits, reloaded on every entry to WAIT, never wraps.
// TESTING
//  Clear low, release before an edge -> outputs all 0 and Run = 0 during reset; T0 strobes on the 1st edge after release.
//  IR = 32'h18910000 (add r1,r2,r3) -> 6 cycles: T3 Grb/Y_enable, T4 Grc/ZLowIn with ALU_op = 00011, T5 Gra/R_in, then T0.
//  IR = 32'h10800014 (st 0x14(r1)), MEM_WAIT = 0 -> RAM_write high in T7 only, exactly 1 cycle; MDR_read = 0 in T6.
//  br with CON_FF = 0, then with CON_FF = 1 -> PC_enable absent in T6, then present in T6.
//  MEM_WAIT = 3 -> MDR_read high for 1 + 3 cycles in fetch; MDR_enable high only in the last of those cycles.
//  halt opcode -> Run falls after T2 and the FSM stays in HALT 20 cycles. Clear pulsed low mid-ld at T5 -> immediately RST with all outputs 0.

Source files
------------

// File: rtl/control_unit.sv
// Moore sequencer for the datapath: fetch T0-T2, per-opcode execute steps T3-T7,
// with an optional WAIT state that stretches memory reads by MEM_WAIT cycles.
module control_unit #(
    parameter int MEM_WAIT = 0
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic [31:0] IR,
    input  logic       CON_FF,
    output logic       PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, BAout, Cout,
    output logic       PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable,
    output logic       ZLowIn, ZHighIn, HI_enable, LO_enable, CON_enable, OutPort_enable, RAM_write,
    output logic       Gra, Grb, Grc, R_in, R_out,
    output logic [4:0] ALU_op,
    output logic       Run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001, OP_ROR  = 5'b01010, OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001, OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

    // WAIT counts down from MEM_WAIT-1 so its final cycle is the one with cnt == 0.
    localparam logic       HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [3:0] WAIT_INIT = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       wait_ld_q, wait_ld_d;
    logic [4:0] opc_s;
    logic       unused_ir_s;

    assign opc_s       = IR[31:27];
    assign unused_ir_s = ^IR[26:0];

    // State, wait counter and WAIT return-target registers.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q    <= S_RST;
            wait_cnt_q <= 4'd0;
            wait_ld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wait_ld_q  <= wait_ld_d;
        end
    end

    // Next-state and strobe decode from (state, opcode).
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wait_ld_d  = wait_ld_q;
        {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, BAout, Cout} = 9'd0;
        {PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable} = 7'd0;
        {ZLowIn, ZHighIn, HI_enable, LO_enable, CON_enable, OutPort_enable, RAM_write} = 7'd0;
        {Gra, Grb, Grc, R_in, R_out} = 5'd0;
        ALU_op = 5'd0;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0: begin
                PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1;
                if (HAS_WAIT) begin
                    state_d = S_WAIT; wait_cnt_d = WAIT_INIT; wait_ld_d = 1'b0;
                end else begin
                    MDR_enable = 1'b1; state_d = S_T2;
                end
            end
            S_WAIT: begin
                MDR_read = 1'b1;
                if (wait_cnt_q == 4'd0) begin
                    MDR_enable = 1'b1;
                    state_d = wait_ld_q ? S_T7 : S_T2;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_T2: begin
                MDRout = 1'b1; IR_enable = 1'b1;
                case (opc_s)
                    OP_HALT: state_d = S_HALT;
                    OP_NOP:  state_d = S_T0;
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
                    OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV,
                    OP_NEG, OP_NOT, OP_BR, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:
                        state_d = S_T3;
                    default: state_d = S_T0;
                endcase
            end
            S_T3: begin
                state_d = S_T4;
                case (opc_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    OP_MUL, OP_DIV: begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    OP_NEG, OP_NOT: begin Grb = 1'b1; R_out = 1'b1; ALU_op = opc_s; ZLowIn = 1'b1; end
                    OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
                    OP_BR: begin Gra = 1'b1; R_out = 1'b1; CON_enable = 1'b1; end
                    OP_JR: begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; state_d = S_T0; end
                    OP_IN: begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; state_d = S_T0; end
                    OP_OUT: begin Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; state_d = S_T0; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; R_in = 1'b1; state_d = S_T0; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; R_in = 1'b1; state_d = S_T0; end
                    default: state_d = S_T0;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (opc_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                        begin Grc = 1'b1; R_out = 1'b1; ALU_op = opc_s; ZLowIn = 1'b1; end
                    OP_ADDI, OP_ANDI, OP_ORI: begin Cout = 1'b1; ALU_op = opc_s; ZLowIn = 1'b1; end
                    OP_MUL, OP_DIV: begin
                        Grb = 1'b1; R_out = 1'b1; ALU_op = opc_s; ZHighIn = 1'b1; ZLowIn = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; state_d = S_T0; end
                    OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; ALU_op = OP_ADD; ZLowIn = 1'b1; end
                    OP_BR: begin PCout = 1'b1; Y_enable = 1'b1; end
                    default: state_d = S_T0;
                endcase
            end
            S_T5: begin
                state_d = S_T6;
                case (opc_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
                        begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; state_d = S_T0; end
                    OP_MUL, OP_DIV: begin ZLowout = 1'b1; LO_enable = 1'b1; end
                    OP_LD, OP_ST: begin ZLowout = 1'b1; MAR_enable = 1'b1; end
                    OP_BR: begin Cout = 1'b1; ALU_op = OP_ADD; ZLowIn = 1'b1; end
                    default: state_d = S_T0;
                endcase
            end
            S_T6: begin
                state_d = S_T0;
                case (opc_s)
                    OP_MUL, OP_DIV: begin ZHighout = 1'b1; HI_enable = 1'b1; end
                    OP_LD: begin
                        MDR_read = 1'b1;
                        if (HAS_WAIT) begin
                            state_d = S_WAIT; wait_cnt_d = WAIT_INIT; wait_ld_d = 1'b1;
                        end else begin
                            MDR_enable = 1'b1; state_d = S_T7;
                        end
                    end
                    OP_ST: begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; state_d = S_T7; end
                    OP_BR: begin ZLowout = 1'b1; PC_enable = CON_FF; end
                    default: state_d = S_T0;
                endcase
            end
            S_T7: begin
                state_d = S_T0;
                case (opc_s)
                    OP_LD: begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    OP_ST: RAM_write = 1'b1;
                    default: state_d = S_T0;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
        Run = (state_q != S_RST) && (state_q != S_HALT);
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one instance with MEM_WAIT=0 for instruction
// sequences, one with MEM_WAIT=3 for the stretched fetch read.
module tb_control_unit;

    logic        Clock, Clear, CON_FF;
    logic [31:0] IR;
    logic [27:0] s0, s3;
    logic [4:0]  a0, a3;
    logic        r0, r3;
    int          checks = 0;
    int          errors = 0;

    localparam logic [27:0] PCOUT = 28'd1 << 0,  ZLOWOUT = 28'd1 << 1,  ZHIGHOUT = 28'd1 << 2;
    localparam logic [27:0] MDROUT = 28'd1 << 3, HIOUT = 28'd1 << 4,    LOOUT = 28'd1 << 5;
    localparam logic [27:0] INOUT = 28'd1 << 6,  BAOUT = 28'd1 << 7,    COUT = 28'd1 << 8;
    localparam logic [27:0] PC_EN = 28'd1 << 9,  INCPC = 28'd1 << 10,   MAR_EN = 28'd1 << 11;
    localparam logic [27:0] MDR_EN = 28'd1 << 12, MDR_RD = 28'd1 << 13, IR_EN = 28'd1 << 14;
    localparam logic [27:0] Y_EN = 28'd1 << 15,  ZLOWIN = 28'd1 << 16,  ZHIGHIN = 28'd1 << 17;
    localparam logic [27:0] HI_EN = 28'd1 << 18, LO_EN = 28'd1 << 19,   CON_EN = 28'd1 << 20;
    localparam logic [27:0] OUTP_EN = 28'd1 << 21, RAM_WR = 28'd1 << 22, GRA = 28'd1 << 23;
    localparam logic [27:0] GRB = 28'd1 << 24,   GRC = 28'd1 << 25,     RIN = 28'd1 << 26;
    localparam logic [27:0] ROUT = 28'd1 << 27;
    localparam logic [27:0] T0M = PCOUT | MAR_EN | INCPC | ZLOWIN;
    localparam logic [27:0] T1M = ZLOWOUT | PC_EN | MDR_RD | MDR_EN;
    localparam logic [27:0] T2M = MDROUT | IR_EN;

    control_unit #(.MEM_WAIT(0)) u0 (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
        .PCout(s0[0]), .ZLowout(s0[1]), .ZHighout(s0[2]), .MDRout(s0[3]), .HIout(s0[4]),
        .LOout(s0[5]), .InPortout(s0[6]), .BAout(s0[7]), .Cout(s0[8]), .PC_enable(s0[9]),
        .IncPC(s0[10]), .MAR_enable(s0[11]), .MDR_enable(s0[12]), .MDR_read(s0[13]),
        .IR_enable(s0[14]), .Y_enable(s0[15]), .ZLowIn(s0[16]), .ZHighIn(s0[17]),
        .HI_enable(s0[18]), .LO_enable(s0[19]), .CON_enable(s0[20]), .OutPort_enable(s0[21]),
        .RAM_write(s0[22]), .Gra(s0[23]), .Grb(s0[24]), .Grc(s0[25]), .R_in(s0[26]),
        .R_out(s0[27]), .ALU_op(a0), .Run(r0)
    );

    control_unit #(.MEM_WAIT(3)) u3 (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
        .PCout(s3[0]), .ZLowout(s3[1]), .ZHighout(s3[2]), .MDRout(s3[3]), .HIout(s3[4]),
        .LOout(s3[5]), .InPortout(s3[6]), .BAout(s3[7]), .Cout(s3[8]), .PC_enable(s3[9]),
        .IncPC(s3[10]), .MAR_enable(s3[11]), .MDR_enable(s3[12]), .MDR_read(s3[13]),
        .IR_enable(s3[14]), .Y_enable(s3[15]), .ZLowIn(s3[16]), .ZHighIn(s3[17]),
        .HI_enable(s3[18]), .LO_enable(s3[19]), .CON_enable(s3[20]), .OutPort_enable(s3[21]),
        .RAM_write(s3[22]), .Gra(s3[23]), .Grb(s3[24]), .Grc(s3[25]), .R_in(s3[26]),
        .R_out(s3[27]), .ALU_op(a3), .Run(r3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got run/alu/strobes=%h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and compare the MEM_WAIT=0 instance.
    task automatic step(input string tag, input logic [27:0] m, input logic [4:0] alu, input logic run);
        @(posedge Clock);
        #1;
        check(tag, {r0, a0, s0}, {run, alu, m});
    endtask

    task automatic step3(input string tag, input logic [27:0] m);
        @(posedge Clock);
        #1;
        check(tag, {r3, a3, s3}, {1'b1, 5'd0, m});
    endtask

    task automatic fetch12(input string tag);
        step({tag, "_T1"}, T1M, 5'd0, 1'b1);
        step({tag, "_T2"}, T2M, 5'd0, 1'b1);
    endtask

    initial begin
        Clear = 1'b0; CON_FF = 1'b0; IR = 32'h18910000;
        #12;
        check("rst_u0", {r0, a0, s0}, 34'd0);
        check("rst_u3", {r3, a3, s3}, 34'd0);
        @(negedge Clock);
        Clear = 1'b1;

        // Stretched fetch read on the MEM_WAIT=3 instance
        step3("w_T0", T0M);
        check("first_T0_u0", {r0, a0, s0}, {1'b1, 5'd0, T0M});
        step3("w_T1", ZLOWOUT | PC_EN | MDR_RD);
        step3("w_W1", MDR_RD);
        step3("w_W2", MDR_RD);
        step3("w_W3", MDR_RD | MDR_EN);
        step3("w_T2", T2M);

        @(negedge Clock);
        Clear = 1'b0;
        #1;
        check("rst2_u0", {r0, a0, s0}, 34'd0);
        @(negedge Clock);
        Clear = 1'b1;

        // add r1,r2,r3
        step("add_T0", T0M, 5'd0, 1'b1);
        fetch12("add");
        step("add_T3", GRB | ROUT | Y_EN, 5'd0, 1'b1);
        step("add_T4", GRC | ROUT | ZLOWIN, 5'b00011, 1'b1);
        step("add_T5", ZLOWOUT | GRA | RIN, 5'd0, 1'b1);
        step("add_end", T0M, 5'd0, 1'b1);

        // st 0x14(r1)
        IR = 32'h10800014;
        fetch12("st");
        step("st_T3", GRB | BAOUT | Y_EN, 5'd0, 1'b1);
        step("st_T4", COUT | ZLOWIN, 5'b00011, 1'b1);
        step("st_T5", ZLOWOUT | MAR_EN, 5'd0, 1'b1);
        step("st_T6", GRA | ROUT | MDR_EN, 5'd0, 1'b1);
        step("st_T7", RAM_WR, 5'd0, 1'b1);
        step("st_end", T0M, 5'd0, 1'b1);

        // br, condition false then true
        for (int c = 0; c < 2; c++) begin
            IR = 32'h98000000;
            CON_FF = (c == 1);
            fetch12("br");
            step("br_T3", GRA | ROUT | CON_EN, 5'd0, 1'b1);
            step("br_T4", PCOUT | Y_EN, 5'd0, 1'b1);
            step("br_T5", COUT | ZLOWIN, 5'b00011, 1'b1);
            step(c == 1 ? "br_T6_taken" : "br_T6_not", c == 1 ? (ZLOWOUT | PC_EN) : ZLOWOUT, 5'd0, 1'b1);
            step("br_end", T0M, 5'd0, 1'b1);
        end
        CON_FF = 1'b0;

        // mul
        IR = 32'h78000000;
        fetch12("mul");
        step("mul_T3", GRA | ROUT | Y_EN, 5'd0, 1'b1);
        step("mul_T4", GRB | ROUT | ZHIGHIN | ZLOWIN, 5'b01111, 1'b1);
        step("mul_T5", ZLOWOUT | LO_EN, 5'd0, 1'b1);
        step("mul_T6", ZHIGHOUT | HI_EN, 5'd0, 1'b1);
        step("mul_end", T0M, 5'd0, 1'b1);

        // neg
        IR = 32'h88000000;
        fetch12("neg");
        step("neg_T3", GRB | ROUT | ZLOWIN, 5'b10001, 1'b1);
        step("neg_T4", ZLOWOUT | GRA | RIN, 5'd0, 1'b1);
        step("neg_end", T0M, 5'd0, 1'b1);

        // nop and an unassigned opcode both return straight to T0
        IR = 32'hD0000000;
        fetch12("nop");
        step("nop_end", T0M, 5'd0, 1'b1);
        IR = 32'hF8000000;
        fetch12("undef");
        step("undef_end", T0M, 5'd0, 1'b1);

        // ld aborted by Clear at T5
        IR = 32'h00000000;
        fetch12("ld");
        step("ld_T3", GRB | BAOUT | Y_EN, 5'd0, 1'b1);
        step("ld_T4", COUT | ZLOWIN, 5'b00011, 1'b1);
        step("ld_T5", ZLOWOUT | MAR_EN, 5'd0, 1'b1);
        Clear = 1'b0;
        #1;
        check("ld_abort", {r0, a0, s0}, 34'd0);
        @(negedge Clock);
        Clear = 1'b1;
        step("abort_T0", T0M, 5'd0, 1'b1);

        // halt
        IR = 32'hD8000000;
        fetch12("halt");
        for (int i = 0; i < 20; i++) step("halt_hold", 28'd0, 5'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
